initfc_dllp_receiver: RTL
=========================

Name: initfc_dllp_receiver

Overview:
Receive-side counterpart of the InitFC DLLP generator in the DLCMSM dll_active path. It checks the CRC16 of incoming 48-bit DLLPs and decodes InitFC1, InitFC2 and UpdateFC types. It latches the link partner's advertised P/NP/CPL header and data credits and raises the FI1/FI2 flags that the DLCMSM uses to leave DL_Init1 and DL_Init2. The latched credits feed the TX credit-limit logic.

Parameters:
CRC16_POLY, 16'h100B, DLLP CRC16 polynomial; passed to the CRC sub-module.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
dlc_state_i  input  2  DLCMSM state: 00 DL_Inactive, 01 DL_Init1, 10 DL_Init2, 11 DL_Active
dll_dllp_i  input  48  received DLLP: [31:0] body, [47:32] CRC16
dll_dllp_valid_i  input  1  dll_dllp_i valid this cycle
p_hdr_credit_o  output  8  partner Posted header credits
p_data_credit_o  output  12  partner Posted data credits
np_hdr_credit_o  output  8  partner Non-Posted header credits
np_data_credit_o  output  12  partner Non-Posted data credits
cpl_hdr_credit_o  output  8  partner Completion header credits
cpl_data_credit_o  output  12  partner Completion data credits
credit_valid_o  output  3  per-type credits latched; bit0 P, bit1 NP, bit2 CPL
hdr_inf_o  output  3  per-type header credit infinite (advertised 0)
data_inf_o  output  3  per-type data credit infinite (advertised 0)
fi1_o  output  1  FI1 flag, sticky
fi2_o  output  1  FI2 flag, sticky
crc_err_o  output  1  one-cycle pulse on a CRC-mismatched DLLP

Behaviour:
- Reset: all credit outputs 0; credit_valid_o, hdr_inf_o, data_inf_o 3'b000; fi1_o, fi2_o, crc_err_o 0; pipeline valid 0.
- Field extraction:
  - type = dllp[7:4]
  - hdr = {dllp[13:8], dllp[23:22]}
  - data = {dllp[19:16], dllp[31:24]}
  - reserved bits are ignored.
- Type codes:
  - InitFC1: P 0100, NP 0101, CPL 0110
  - InitFC2: P 1100, NP 1101, CPL 1110
  - UpdateFC: P 1000, NP 1001, CPL 1010
  - All other codes are ignored without error.
- Stage 1 (cycle N, valid sampled):
  - Register the DLLP body.
  - Register crc_ok = (dllp[47:32] == CRC16 of dllp[31:0]).
  - Register s1_valid.
- Stage 2 (edge N+1), when s1_valid is set:
  - If !crc_ok: crc_err_o = 1 for exactly one cycle (visible at N+2); no other state changes.
  - If crc_ok: decode and update registers; outputs are visible at N+2. Total latency is 2 cycles.
- Back-to-back valid DLLPs are accepted every cycle with no stall; there is no ready signal.
- Credit latch:
  - In DL_Init1 or DL_Init2, a CRC-good InitFC1 or InitFC2 of type T latches hdr/data for T only if credit_valid_o[T] == 0. It then sets credit_valid_o[T], hdr_inf_o[T] = (hdr == 0) and data_inf_o[T] = (data == 0).
  - The first advertised value wins. Later InitFC for the same T does not modify credits.
  - UpdateFC never modifies latched credits in this block.
- FI1:
  - Set at the update edge where credit_valid_o becomes 3'b111, in DL_Init1 or DL_Init2.
  - Sticky until cleared.
- FI2:
  - Set in DL_Init2 only, on any CRC-good InitFC2 (any type) or UpdateFC (any type).
  - Sticky until cleared.
  - Ignored in DL_Init1. Never set while FI1 is 0 in the same cycle; evaluate FI1 first, and if the same DLLP completes FI1 and qualifies for FI2, set both.
- DL_Active: credits and flags are held; InitFC DLLPs are ignored; CRC checking and crc_err_o remain active.
- dlc_state_i == DL_Inactive: synchronous clear of all credits, valid/inf bits, FI1 and FI2 at the next edge. The pipeline stage is flushed; a DLLP in flight is discarded and produces no crc_err_o.
- Reset asserted mid-operation: everything returns to reset values asynchronously; there is no partial update.
- A dlc_state_i change between stage 1 and stage 2: stage 2 uses the dlc_state_i value sampled at the stage-2 edge.

Decomposition:
- Shared package dll_pkg:
  - DLC state encodings
  - 4-bit DLLP type constants (InitFC1/2, UpdateFC per P/NP/CPL)
  - FC type index constants P=0, NP=1, CPL=2
  - CRC16_POLY default
- Sub-module: reuse the codebase CRC block dllp_crc16_generator (combinational, dllp_data[31:0] -> crc16_out[15:0]), one instance on dll_dllp_i[31:0]. This is shared with the generator so TX and RX CRCs match.

Test Plan:
- DL_Init1; send CRC-good InitFC1_P (hdr=8'h20, data=12'h100), InitFC1_NP (8'h10, 12'h000), InitFC1_CPL (8'h00, 12'h000) on consecutive cycles -> at 2 cycles after the last DLLP:
  - p=20/100, np=10/000, cpl=00/000
  - credit_valid_o=111, hdr_inf_o=100, data_inf_o=110
  - fi1_o=1 on the same cycle credit_valid_o reaches 111; fi2_o=0
- Repeat InitFC1_P with hdr=8'h55 after latching -> p_hdr_credit_o stays 8'h20.
- InitFC1_NP with CRC bit 40 flipped -> crc_err_o pulses 1 cycle at N+2; credit_valid_o[1] stays 0; fi1_o unchanged.
- After FI1, DL_Init2; send CRC-good UpdateFC_P (type 1000) -> fi2_o=1 at N+2; credits unchanged. The same DLLP sent in DL_Init1 -> fi2_o stays 0.
- With all credits latched and FI1/FI2 set, drive dlc_state_i=00 for one cycle with a valid DLLP in flight -> next cycle all outputs 0 and no crc_err_o. Also assert rst_n low mid-stream -> outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/dll_pkg.sv
// Shared DLL definitions: DLCMSM state encodings, DLLP flow-control type codes
// and the decoded-field layout used by the InitFC receive path.
package dll_pkg;

   typedef enum logic [1:0] {
      DL_INACTIVE = 2'b00,
      DL_INIT1    = 2'b01,
      DL_INIT2    = 2'b10,
      DL_ACTIVE   = 2'b11
   } dlc_state_e;

   localparam logic [3:0] DLLP_INITFC1_P   = 4'b0100;
   localparam logic [3:0] DLLP_INITFC1_NP  = 4'b0101;
   localparam logic [3:0] DLLP_INITFC1_CPL = 4'b0110;
   localparam logic [3:0] DLLP_INITFC2_P   = 4'b1100;
   localparam logic [3:0] DLLP_INITFC2_NP  = 4'b1101;
   localparam logic [3:0] DLLP_INITFC2_CPL = 4'b1110;
   localparam logic [3:0] DLLP_UPDFC_P     = 4'b1000;
   localparam logic [3:0] DLLP_UPDFC_NP    = 4'b1001;
   localparam logic [3:0] DLLP_UPDFC_CPL   = 4'b1010;

   localparam int unsigned FC_P   = 0;
   localparam int unsigned FC_NP  = 1;
   localparam int unsigned FC_CPL = 2;

   localparam logic [15:0] CRC16_POLY_DEFAULT = 16'h100B;

   typedef enum logic [1:0] {
      FC_CLASS_NONE,
      FC_CLASS_INIT1,
      FC_CLASS_INIT2,
      FC_CLASS_UPDATE
   } fc_class_e;

   typedef struct packed {
      logic [3:0]  ftype;
      logic [7:0]  hdr;
      logic [11:0] data;
   } dllp_fields_t;

   function automatic dllp_fields_t dllp_extract(input logic [31:0] body);
      dllp_fields_t f;
      f.ftype = body[7:4];
      f.hdr   = {body[13:8], body[23:22]};
      f.data  = {body[19:16], body[31:24]};
      return f;
   endfunction

   function automatic fc_class_e dllp_class(input logic [3:0] t);
      fc_class_e c;
      case (t)
         DLLP_INITFC1_P, DLLP_INITFC1_NP, DLLP_INITFC1_CPL: c = FC_CLASS_INIT1;
         DLLP_INITFC2_P, DLLP_INITFC2_NP, DLLP_INITFC2_CPL: c = FC_CLASS_INIT2;
         DLLP_UPDFC_P,   DLLP_UPDFC_NP,   DLLP_UPDFC_CPL:   c = FC_CLASS_UPDATE;
         default:                                           c = FC_CLASS_NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/dllp_crc16_generator.sv
// Combinational DLLP CRC16 over a 32-bit body: MSB-first, seed 16'hFFFF,
// result inverted. Shared by TX and RX so both ends compute identical CRCs.
module dllp_crc16_generator
   import dll_pkg::*;
#(
   parameter logic [15:0] CRC16_POLY = CRC16_POLY_DEFAULT
) (
   input  logic [31:0] dllp_data,
   output logic [15:0] crc16_out
);

   logic [15:0] crc;
   logic        fb;

   always_comb begin
      crc = '1;
      fb  = 1'b0;
      for (int unsigned i = 0; i < 32; i++) begin
         fb  = crc[15] ^ dllp_data[31 - i];
         crc = {crc[14:0], 1'b0};
         if (fb) crc = crc ^ CRC16_POLY;
      end
      crc16_out = ~crc;
   end

endmodule

// File: rtl/initfc_dllp_receiver.sv
// InitFC/UpdateFC DLLP receiver: CRC check in stage 1, decode and credit/FI
// flag update in stage 2. Latched credits feed the TX credit-limit logic.
module initfc_dllp_receiver
   import dll_pkg::*;
#(
   parameter logic [15:0] CRC16_POLY = CRC16_POLY_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  dlc_state_i,
   input  logic [47:0] dll_dllp_i,
   input  logic        dll_dllp_valid_i,
   output logic [7:0]  p_hdr_credit_o,
   output logic [11:0] p_data_credit_o,
   output logic [7:0]  np_hdr_credit_o,
   output logic [11:0] np_data_credit_o,
   output logic [7:0]  cpl_hdr_credit_o,
   output logic [11:0] cpl_data_credit_o,
   output logic [2:0]  credit_valid_o,
   output logic [2:0]  hdr_inf_o,
   output logic [2:0]  data_inf_o,
   output logic        fi1_o,
   output logic        fi2_o,
   output logic        crc_err_o
);

   dlc_state_e   st;
   logic [15:0]  crc_calc;

   dllp_fields_t s1_fields_q, s1_fields_d;
   logic         s1_crc_ok_q, s1_crc_ok_d;
   logic         s1_valid_q, s1_valid_d;

   logic [2:0][7:0]  hdr_q, hdr_d;
   logic [2:0][11:0] data_q, data_d;
   logic [2:0]       cvalid_q, cvalid_d;
   logic [2:0]       hdr_inf_q, hdr_inf_d;
   logic [2:0]       data_inf_q, data_inf_d;
   logic             fi1_q, fi1_d;
   logic             fi2_q, fi2_d;
   logic             crc_err_q, crc_err_d;

   fc_class_e        cls;
   logic [1:0]       idx;
   logic             in_init;

   assign st = dlc_state_e'(dlc_state_i);

   dllp_crc16_generator #(
      .CRC16_POLY (CRC16_POLY)
   ) u_crc (
      .dllp_data (dll_dllp_i[31:0]),
      .crc16_out (crc_calc)
   );

   always_comb begin
      s1_valid_d  = dll_dllp_valid_i && (st != DL_INACTIVE);
      s1_fields_d = dll_dllp_valid_i ? dllp_extract(dll_dllp_i[31:0]) : s1_fields_q;
      s1_crc_ok_d = dll_dllp_valid_i ? (dll_dllp_i[47:32] == crc_calc) : s1_crc_ok_q;

      hdr_d      = hdr_q;
      data_d     = data_q;
      cvalid_d   = cvalid_q;
      hdr_inf_d  = hdr_inf_q;
      data_inf_d = data_inf_q;
      fi1_d      = fi1_q;
      fi2_d      = fi2_q;
      crc_err_d  = 1'b0;

      cls     = dllp_class(s1_fields_q.ftype);
      idx     = s1_fields_q.ftype[1:0];
      in_init = (st == DL_INIT1) || (st == DL_INIT2);

      if (st == DL_INACTIVE) begin
         hdr_d      = '0;
         data_d     = '0;
         cvalid_d   = '0;
         hdr_inf_d  = '0;
         data_inf_d = '0;
         fi1_d      = 1'b0;
         fi2_d      = 1'b0;
      end else if (s1_valid_q) begin
         if (!s1_crc_ok_q) begin
            crc_err_d = 1'b1;
         end else if (in_init) begin
            // First advertisement per type wins; later InitFCs are ignored.
            if ((cls == FC_CLASS_INIT1 || cls == FC_CLASS_INIT2) && !cvalid_q[idx]) begin
               hdr_d[idx]      = s1_fields_q.hdr;
               data_d[idx]     = s1_fields_q.data;
               cvalid_d[idx]   = 1'b1;
               hdr_inf_d[idx]  = (s1_fields_q.hdr == '0);
               data_inf_d[idx] = (s1_fields_q.data == '0);
            end
            if (cvalid_q != 3'b111 && cvalid_d == 3'b111) fi1_d = 1'b1;
            // FI2 is gated on the updated FI1 so one DLLP can set both.
            if (st == DL_INIT2 && fi1_d &&
                (cls == FC_CLASS_INIT2 || cls == FC_CLASS_UPDATE)) fi2_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_fields_q <= '0;
         s1_crc_ok_q <= 1'b0;
         s1_valid_q  <= 1'b0;
         hdr_q       <= '0;
         data_q      <= '0;
         cvalid_q    <= '0;
         hdr_inf_q   <= '0;
         data_inf_q  <= '0;
         fi1_q       <= 1'b0;
         fi2_q       <= 1'b0;
         crc_err_q   <= 1'b0;
      end else begin
         s1_fields_q <= s1_fields_d;
         s1_crc_ok_q <= s1_crc_ok_d;
         s1_valid_q  <= s1_valid_d;
         hdr_q       <= hdr_d;
         data_q      <= data_d;
         cvalid_q    <= cvalid_d;
         hdr_inf_q   <= hdr_inf_d;
         data_inf_q  <= data_inf_d;
         fi1_q       <= fi1_d;
         fi2_q       <= fi2_d;
         crc_err_q   <= crc_err_d;
      end
   end

   assign p_hdr_credit_o    = hdr_q[FC_P];
   assign p_data_credit_o   = data_q[FC_P];
   assign np_hdr_credit_o   = hdr_q[FC_NP];
   assign np_data_credit_o  = data_q[FC_NP];
   assign cpl_hdr_credit_o  = hdr_q[FC_CPL];
   assign cpl_data_credit_o = data_q[FC_CPL];
   assign credit_valid_o    = cvalid_q;
   assign hdr_inf_o         = hdr_inf_q;
   assign data_inf_o        = data_inf_q;
   assign fi1_o             = fi1_q;
   assign fi2_o             = fi2_q;
   assign crc_err_o         = crc_err_q;

endmodule
